// File: rtl/stopwatch_pkg.sv
// Shared state encoding and widths for the stopwatch front-panel controller.
package stopwatch_pkg;
  localparam int TIME_W_DEF = 24;
  localparam int ST_W       = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_e;
endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Panel/core/display bundle: master is the board+core side, slave is the controller.
interface stopwatch_ctrl_if
  import stopwatch_pkg::*;
#(
  parameter int TIME_W = TIME_W_DEF
);
  logic              btn_start;
  logic              btn_lap;
  logic              btn_clr;
  logic [TIME_W-1:0] core_time;
  logic              toggle;
  logic              sw_reset;
  logic [TIME_W-1:0] disp_time;
  logic              lap_active;
  logic [ST_W-1:0]   state;

  modport master (
    output btn_start, btn_lap, btn_clr, core_time,
    input  toggle, sw_reset, disp_time, lap_active, state
  );
  modport slave (
    input  btn_start, btn_lap, btn_clr, core_time,
    output toggle, sw_reset, disp_time, lap_active, state
  );
endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, one-cycle press pulse.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synced samples that disagree with the accepted level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        press <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front panel: debounced buttons, IDLE/RUN/PAUSE/LAP FSM, core control, display mux.
// Define STOPWATCH_LAP_EN to build the lap button, LAP state and lap snapshot register.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIME_W          = TIME_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  stopwatch_ctrl_if.slave sw
);
  logic start_p, clr_p, lap_p;
  logic ev_start, ev_clr, ev_lap;

  sw_state_e st_q, st_d;
  logic      tog_q, tog_d;
  logic      srst_q, srst_d;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .reset(reset), .raw(sw.btn_start), .press(start_p)
  );
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .reset(reset), .raw(sw.btn_clr), .press(clr_p)
  );
`ifdef STOPWATCH_LAP_EN
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk(clk), .reset(reset), .raw(sw.btn_lap), .press(lap_p)
  );
`else
  assign lap_p = 1'b0;
`endif

  // coincident events: clear beats start beats lap, losers are discarded
  assign ev_clr   = clr_p;
  assign ev_start = start_p & ~clr_p;
  assign ev_lap   = lap_p & ~start_p & ~clr_p;

  always_comb begin
    st_d   = st_q;
    srst_d = 1'b0;
    unique case (st_q)
      ST_IDLE:  if (ev_clr) srst_d = 1'b1;
                else if (ev_start) st_d = ST_RUN;
      ST_RUN:   if (ev_start) st_d = ST_PAUSE;
                else if (ev_lap) st_d = ST_LAP;
      ST_LAP:   if (ev_start) st_d = ST_PAUSE;
                else if (ev_lap) st_d = ST_RUN;
      ST_PAUSE: if (ev_clr) begin
                  st_d   = ST_IDLE;
                  srst_d = 1'b1;
                end else if (ev_start) st_d = ST_RUN;
      default:  st_d = ST_IDLE;
    endcase
    tog_d = (st_d == ST_RUN) || (st_d == ST_LAP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= ST_IDLE;
      tog_q  <= 1'b0;
      srst_q <= 1'b1;
    end else begin
      st_q   <= st_d;
      tog_q  <= tog_d;
      srst_q <= srst_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [TIME_W-1:0] lap_reg;

  // snapshot is taken on the same edge that enters LAP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  lap_reg <= '0;
    else if (st_q == ST_RUN && st_d == ST_LAP)   lap_reg <= sw.core_time;
  end

  assign sw.lap_active = (st_q == ST_LAP);
  assign sw.disp_time  = sw.lap_active ? lap_reg : sw.core_time;
`else
  assign sw.lap_active = 1'b0;
  assign sw.disp_time  = sw.core_time;
`endif

  assign sw.state    = st_q;
  assign sw.toggle   = tog_q;
  assign sw.sw_reset = srst_q;
endmodule
